pkt_queue_arbiter: RTL and testbench

PKT_QUEUE_ARBITER -- requirements
Module: pkt_queue_arbiter

---
 rtl/pkt_queue_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_pkt_queue_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pkt_queue_arbiter
// Description : Round-robin packet arbiter feeding a downstream packet queue.
//               Grants one requester for a whole packet, forwards its beats
//               with one cycle of latency, and cuts packets that stall or
//               overrun MAX_PKT_LEN. The rest of a cut packet is drained.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_queue_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PORTS   = 4,
  parameter int MAX_PKT_LEN = 2047
) (
  input  logic                            clk,
  input  logic                            i_reset,
  input  logic [NUM_PORTS-1:0]            i_req,
  input  logic [NUM_PORTS-1:0]            i_valid,
  input  logic [NUM_PORTS-1:0]            i_last,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_PORTS-1:0]            o_ready,
  output logic [NUM_PORTS-1:0]            o_grant,
  input  logic                            i_queue_full,
  output logic                            o_write_en,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_pkt_done,
  output logic                            o_err_trunc,
  output logic                            o_err_len
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
  // Count value held while the final permitted beat is being accepted.
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [PTR_W-1:0] C_TOP_IDX  = PTR_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   pkt_done_q, pkt_done_d;
  logic                   err_trunc_q, err_trunc_d;
  logic                   err_len_q, err_len_d;

  logic                   arb_found;
  logic [PTR_W-1:0]       arb_idx;
  logic [PTR_W-1:0]       arb_next;
  logic                   g_req, g_valid, g_last, g_accept;
  logic [DATA_WIDTH-1:0]  g_data;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin : p_arb
    int               cand;
    logic [PTR_W-1:0] cidx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cidx = PTR_W'(cand);
      if (!arb_found && i_req[cidx]) begin
        arb_found = 1'b1;
        arb_idx   = cidx;
      end
    end
  end

  assign arb_next = (arb_idx == C_TOP_IDX) ? '0 : arb_idx + PTR_W'(1);

  // Controls and data of the currently granted port (grant is one-hot).
  always_comb begin
    g_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_q[k]) g_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_req    = |(i_req   & grant_q);
  assign g_valid  = |(i_valid & grant_q);
  assign g_last   = |(i_last  & grant_q);
  assign g_accept = (state_q == ST_XFER) && g_valid && !i_queue_full;

  // Ready follows queue space while transferring; drain accepts everything.
  always_comb begin
    o_ready = '0;
    if (!i_reset) begin
      if (state_q == ST_XFER && !i_queue_full) o_ready = grant_q;
      else if (state_q == ST_DRAIN)            o_ready = grant_q;
    end
  end

  // Next-state, grant, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    pkt_done_d  = 1'b0;
    err_trunc_d = 1'b0;
    err_len_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d  = NUM_PORTS'(1) << arb_idx;
          rr_ptr_d = arb_next;
          cnt_d    = '0;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (g_accept) begin
          wr_en_d = 1'b1;
          data_d  = g_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (g_last) begin
            pkt_done_d = 1'b1;
            grant_d    = '0;
            state_d    = ST_GAP;
          end else if (cnt_q == C_LAST_CNT) begin
            // Overlong packet: keep the last legal beat, discard the rest.
            err_len_d = 1'b1;
            state_d   = ST_DRAIN;
          end
        end else if (cnt_q == '0) begin
          // Nothing written yet, so a withdrawn request is a clean abort.
          if (!g_req) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          // Bubble inside a packet: queue cannot hold a gapped packet.
          err_trunc_d = 1'b1;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (g_valid && g_last) begin
          grant_d = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      pkt_done_q  <= 1'b0;
      err_trunc_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      pkt_done_q  <= pkt_done_d;
      err_trunc_q <= err_trunc_d;
      err_len_q   <= err_len_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_write_en  = wr_en_q;
  assign o_data      = data_q;
  assign o_pkt_done  = pkt_done_q;
  assign o_err_trunc = err_trunc_q;
  assign o_err_len   = err_len_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_queue_arbiter
// Description : Directed self-checking bench for pkt_queue_arbiter
//               (NUM_PORTS=4, DATA_WIDTH=8, MAX_PKT_LEN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_queue_arbiter;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int ML = 4;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [NP-1:0]   i_req, i_valid, i_last;
  logic [NP*DW-1:0] i_data;
  logic            i_queue_full;
  logic [NP-1:0]   o_ready, o_grant;
  logic            o_write_en;
  logic [DW-1:0]   o_data;
  logic            o_pkt_done, o_err_trunc, o_err_len;

  // {grant[15:12], write_en[11], data[10:3], done, trunc, len}
  logic [15:0]     obs;
  assign obs = {o_grant, o_write_en, o_data, o_pkt_done, o_err_trunc, o_err_len};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pkt_queue_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_PORTS  (NP),
    .MAX_PKT_LEN(ML)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_grant     (o_grant),
    .i_queue_full(i_queue_full),
    .o_write_en  (o_write_en),
    .o_data      (o_data),
    .o_pkt_done  (o_pkt_done),
    .o_err_trunc (o_err_trunc),
    .o_err_len   (o_err_len)
  );

  // One cycle: inputs applied before the edge, expected state after it.
  typedef struct packed {
    logic        rst;
    logic        full;
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  rdy;   // o_ready expected before the edge
    logic [3:0]  gnt;
    logic        we;
    logic [7:0]  dat;   // only compared when we=1
    logic [2:0]  flg;   // {done, trunc, len}
  } row_t;

  function automatic row_t mk(input logic rst, input logic full,
                              input logic [3:0] req, input logic [3:0] valid,
                              input logic [3:0] last, input logic [31:0] data,
                              input logic [3:0] rdy, input logic [3:0] gnt,
                              input logic we, input logic [7:0] dat,
                              input logic [2:0] flg);
    row_t r;
    r = '{rst, full, req, valid, last, data, rdy, gnt, we, dat, flg};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input row_t r);
    i_reset      = r.rst;
    i_queue_full = r.full;
    i_req        = r.req;
    i_valid      = r.valid;
    i_last       = r.last;
    i_data       = r.data;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_req = '1; i_valid = '1; i_last = '0; i_data = '1; i_queue_full = 1'b0;
    step();
    step();
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL reset outputs: got %h want 0000", obs);
    end
    checks++;
    if (o_ready !== 4'h0) begin
      failures++;
      $display("FAIL reset ready: got %b want 0000", o_ready);
    end
    i_reset = 1'b0; i_req = '0; i_valid = '0; i_data = '0;
    step();
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL idle after reset: got %h want 0000", obs);
    end
  endtask

  task automatic test_single();
    row_t rows[$];
    logic [15:0] exp, msk;
    // Port 1 packet A1,A2,A3; port 0 also drives valid but never requests.
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h0,4'h0,32'h0000_0000,4'h0,4'h2,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h3,4'h0,32'h0000_A155,4'h2,4'h2,1'b1,8'hA1,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h3,4'h0,32'h0000_A255,4'h2,4'h2,1'b1,8'hA2,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h3,4'h3,32'h0000_A355,4'h2,4'h0,1'b1,8'hA3,3'b100));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h0,4'h0,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h0,4'h0,1'b0,8'h00,3'b000));
    foreach (rows[c]) begin
      apply_row(rows[c]);
      #1;
      checks++;
      if (o_ready !== rows[c].rdy) begin
        failures++;
        $display("FAIL single ready row %0d: got %b want %b", c, o_ready, rows[c].rdy);
      end
      step();
      exp = {rows[c].gnt, rows[c].we, rows[c].dat, rows[c].flg};
      msk = rows[c].we ? 16'hFFFF : 16'hF807;
      checks++;
      if (((obs ^ exp) & msk) !== 16'h0) begin
        failures++;
        $display("FAIL single outputs row %0d: got grant=%b we=%b data=%h flags=%b want grant=%b we=%b data=%h flags=%b",
                 c, obs[15:12], obs[11], obs[10:3], obs[2:0], exp[15:12], exp[11], exp[10:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    logic [15:0] exp, msk;
    // Reset first so the pointer starts at 0; ports 0 and 2 request throughout.
    rows.push_back(mk(1'b1,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,4'h0,1'b0,8'h00,3'b000));
    for (int p = 0; p < 4; p++) begin
      logic [3:0]  g;
      logic [7:0]  a0, a1, b0, b1;
      g  = (p % 2 == 0) ? 4'h1 : 4'h4;
      a0 = 8'h10 + 8'(2*p); a1 = a0 + 8'h01;
      b0 = 8'h20 + 8'(2*p); b1 = b0 + 8'h01;
      rows.push_back(mk(1'b0,1'b0,4'h5,4'h5,4'h0,{8'h00,b0,8'h00,a0},4'h0,g,1'b0,8'h00,3'b000));
      rows.push_back(mk(1'b0,1'b0,4'h5,4'h5,4'h0,{8'h00,b0,8'h00,a0},g,g,1'b1,(g == 4'h1) ? a0 : b0,3'b000));
      rows.push_back(mk(1'b0,1'b0,4'h5,4'h5,4'h5,{8'h00,b1,8'h00,a1},g,4'h0,1'b1,(g == 4'h1) ? a1 : b1,3'b100));
      rows.push_back(mk(1'b0,1'b0,4'h5,4'h5,4'h0,{8'h00,b1,8'h00,a1},4'h0,4'h0,1'b0,8'h00,3'b000));
    end
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0,4'h0,4'h0,1'b0,8'h00,3'b000));
    foreach (rows[c]) begin
      apply_row(rows[c]);
      #1;
      checks++;
      if (o_ready !== rows[c].rdy) begin
        failures++;
        $display("FAIL round_robin ready row %0d: got %b want %b", c, o_ready, rows[c].rdy);
      end
      step();
      exp = {rows[c].gnt, rows[c].we, rows[c].dat, rows[c].flg};
      msk = rows[c].we ? 16'hFFFF : 16'hF807;
      checks++;
      if (((obs ^ exp) & msk) !== 16'h0) begin
        failures++;
        $display("FAIL round_robin outputs row %0d: got grant=%b we=%b data=%h flags=%b want grant=%b we=%b data=%h flags=%b",
                 c, obs[15:12], obs[11], obs[10:3], obs[2:0], exp[15:12], exp[11], exp[10:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    logic [15:0] exp, msk;
    // Port 3, 5 beats; queue fills after beat 2 and stays full while draining.
    rows.push_back(mk(1'b0,1'b0,4'h8,4'h0,4'h0,32'h0000_0000,4'h0,4'h8,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h8,4'h8,4'h0,32'h3100_0000,4'h8,4'h8,1'b1,8'h31,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h8,4'h8,4'h0,32'h3200_0000,4'h8,4'h8,1'b1,8'h32,3'b000));
    rows.push_back(mk(1'b0,1'b1,4'h8,4'h8,4'h0,32'h3300_0000,4'h0,4'h8,1'b0,8'h00,3'b010));
    rows.push_back(mk(1'b0,1'b1,4'h8,4'h8,4'h0,32'h3300_0000,4'h8,4'h8,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b1,4'h8,4'h8,4'h0,32'h3400_0000,4'h8,4'h8,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b1,4'h8,4'h8,4'h8,32'h3500_0000,4'h8,4'h0,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h0,4'h0,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h0,4'h0,1'b0,8'h00,3'b000));
    foreach (rows[c]) begin
      apply_row(rows[c]);
      #1;
      checks++;
      if (o_ready !== rows[c].rdy) begin
        failures++;
        $display("FAIL stall ready row %0d: got %b want %b", c, o_ready, rows[c].rdy);
      end
      step();
      exp = {rows[c].gnt, rows[c].we, rows[c].dat, rows[c].flg};
      msk = rows[c].we ? 16'hFFFF : 16'hF807;
      checks++;
      if (((obs ^ exp) & msk) !== 16'h0) begin
        failures++;
        $display("FAIL stall outputs row %0d: got grant=%b we=%b data=%h flags=%b want grant=%b we=%b data=%h flags=%b",
                 c, obs[15:12], obs[11], obs[10:3], obs[2:0], exp[15:12], exp[11], exp[10:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_length();
    row_t rows[$];
    logic [15:0] exp, msk;
    // Port 0, 6 beats against a 4-beat limit.
    rows.push_back(mk(1'b0,1'b0,4'h1,4'h0,4'h0,32'h0000_0000,4'h0,4'h1,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h1,4'h1,4'h0,32'h0000_0041,4'h1,4'h1,1'b1,8'h41,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h1,4'h1,4'h0,32'h0000_0042,4'h1,4'h1,1'b1,8'h42,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h1,4'h1,4'h0,32'h0000_0043,4'h1,4'h1,1'b1,8'h43,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h1,4'h1,4'h0,32'h0000_0044,4'h1,4'h1,1'b1,8'h44,3'b001));
    rows.push_back(mk(1'b0,1'b0,4'h1,4'h1,4'h0,32'h0000_0045,4'h1,4'h1,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h1,4'h1,4'h1,32'h0000_0046,4'h1,4'h0,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h0,4'h0,1'b0,8'h00,3'b000));
    foreach (rows[c]) begin
      apply_row(rows[c]);
      #1;
      checks++;
      if (o_ready !== rows[c].rdy) begin
        failures++;
        $display("FAIL length ready row %0d: got %b want %b", c, o_ready, rows[c].rdy);
      end
      step();
      exp = {rows[c].gnt, rows[c].we, rows[c].dat, rows[c].flg};
      msk = rows[c].we ? 16'hFFFF : 16'hF807;
      checks++;
      if (((obs ^ exp) & msk) !== 16'h0) begin
        failures++;
        $display("FAIL length outputs row %0d: got grant=%b we=%b data=%h flags=%b want grant=%b we=%b data=%h flags=%b",
                 c, obs[15:12], obs[11], obs[10:3], obs[2:0], exp[15:12], exp[11], exp[10:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_max_exact();
    row_t rows[$];
    logic [15:0] exp, msk;
    // Port 1, exactly 4 beats with last on the 4th: a normal completion.
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h0,4'h0,32'h0000_0000,4'h0,4'h2,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h2,4'h0,32'h0000_5100,4'h2,4'h2,1'b1,8'h51,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h2,4'h0,32'h0000_5200,4'h2,4'h2,1'b1,8'h52,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h2,4'h0,32'h0000_5300,4'h2,4'h2,1'b1,8'h53,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h2,4'h2,4'h2,32'h0000_5400,4'h2,4'h0,1'b1,8'h54,3'b100));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h0,4'h0,1'b0,8'h00,3'b000));
    foreach (rows[c]) begin
      apply_row(rows[c]);
      #1;
      checks++;
      if (o_ready !== rows[c].rdy) begin
        failures++;
        $display("FAIL max_exact ready row %0d: got %b want %b", c, o_ready, rows[c].rdy);
      end
      step();
      exp = {rows[c].gnt, rows[c].we, rows[c].dat, rows[c].flg};
      msk = rows[c].we ? 16'hFFFF : 16'hF807;
      checks++;
      if (((obs ^ exp) & msk) !== 16'h0) begin
        failures++;
        $display("FAIL max_exact outputs row %0d: got grant=%b we=%b data=%h flags=%b want grant=%b we=%b data=%h flags=%b",
                 c, obs[15:12], obs[11], obs[10:3], obs[2:0], exp[15:12], exp[11], exp[10:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_cancel();
    row_t rows[$];
    logic [15:0] exp, msk;
    // Port 2 granted, waits with nothing written (queue full), then withdraws.
    rows.push_back(mk(1'b0,1'b0,4'h4,4'h0,4'h0,32'h0000_0000,4'h0,4'h4,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b1,4'h4,4'h4,4'h0,32'h0077_0000,4'h0,4'h4,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h4,4'h0,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h0,4'h0,1'b0,8'h00,3'b000));
    foreach (rows[c]) begin
      apply_row(rows[c]);
      #1;
      checks++;
      if (o_ready !== rows[c].rdy) begin
        failures++;
        $display("FAIL cancel ready row %0d: got %b want %b", c, o_ready, rows[c].rdy);
      end
      step();
      exp = {rows[c].gnt, rows[c].we, rows[c].dat, rows[c].flg};
      msk = rows[c].we ? 16'hFFFF : 16'hF807;
      checks++;
      if (((obs ^ exp) & msk) !== 16'h0) begin
        failures++;
        $display("FAIL cancel outputs row %0d: got grant=%b we=%b data=%h flags=%b want grant=%b we=%b data=%h flags=%b",
                 c, obs[15:12], obs[11], obs[10:3], obs[2:0], exp[15:12], exp[11], exp[10:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    logic [15:0] exp, msk;
    // Port 3 packet reset on beat 2; then ports 0 and 3 request together.
    rows.push_back(mk(1'b0,1'b0,4'h8,4'h0,4'h0,32'h0000_0000,4'h0,4'h8,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h8,4'h8,4'h0,32'h6100_0000,4'h8,4'h8,1'b1,8'h61,3'b000));
    rows.push_back(mk(1'b1,1'b0,4'h8,4'h8,4'h0,32'h6200_0000,4'h0,4'h0,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h9,4'h0,4'h0,32'h0000_0000,4'h0,4'h1,1'b0,8'h00,3'b000));
    rows.push_back(mk(1'b0,1'b0,4'h0,4'h0,4'h0,32'h0000_0000,4'h1,4'h0,1'b0,8'h00,3'b000));
    foreach (rows[c]) begin
      apply_row(rows[c]);
      #1;
      checks++;
      if (o_ready !== rows[c].rdy) begin
        failures++;
        $display("FAIL reset_mid ready row %0d: got %b want %b", c, o_ready, rows[c].rdy);
      end
      step();
      exp = {rows[c].gnt, rows[c].we, rows[c].dat, rows[c].flg};
      msk = rows[c].we ? 16'hFFFF : 16'hF807;
      checks++;
      if (((obs ^ exp) & msk) !== 16'h0) begin
        failures++;
        $display("FAIL reset_mid outputs row %0d: got grant=%b we=%b data=%h flags=%b want grant=%b we=%b data=%h flags=%b",
                 c, obs[15:12], obs[11], obs[10:3], obs[2:0], exp[15:12], exp[11], exp[10:3], exp[2:0]);
      end
    end
    checks++;
    if (o_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid data cleared: got %h want 00", o_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_length();
    test_max_exact();
    test_cancel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
